// File: rtl/seg_time_if.sv
// Bundle between the 7-segment display sampler and its consumer.
// Carries the segment inputs, the decoded time handshake and the error flags.
//   master: drives segments, time_ready, err_clr; observes time/flags
//   slave : seg_time_reader side
interface seg_time_if;
   logic [13:0] hr_seg;
   logic [13:0] min_seg;
   logic        am_pm;
   logic [10:0] time_out;
   logic        time_valid;
   logic        time_ready;
   logic        seg_error;
   logic        overrun;
   logic        err_clr;
   logic        tick_error;

   modport master (
      output hr_seg, min_seg, am_pm, time_ready, err_clr,
      input  time_out, time_valid, seg_error, overrun, tick_error
   );

   modport slave (
      input  hr_seg, min_seg, am_pm, time_ready, err_clr,
      output time_out, time_valid, seg_error, overrun, tick_error
   );
endinterface

// File: rtl/seg_time_reader.sv
// Samples a 12-hour 7-segment display, debounces it, decodes it to
// minutes since midnight and publishes each new stable value.
//   CLK, RESET : clock, asynchronous active-high reset
//   bus (slave): hr_seg/min_seg/am_pm in, time_out/time_valid/time_ready
//                handshake, sticky seg_error/overrun/tick_error, err_clr
// Optional: define SEG_TICK_CHECK_EN to build the minute-step checker
// driving tick_error; otherwise tick_error is tied low.
module seg_time_reader #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic     CLK,
   input  logic     RESET,
   seg_time_if.slave bus
);

   typedef enum logic [1:0] {
      WAIT  = 2'd0,
      CHECK = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [7:0]  STABLE  = 8'(STABLE_CYCLES);
   localparam logic [10:0] NO_TIME = 11'h7FF;

   state_t      state;
   logic [28:0] din;
   logic [28:0] samp;
   logic        same;
   logic [7:0]  cnt;
   logic [10:0] last_pub;
   logic [10:0] time_out_q;
   logic        time_valid_q;
   logic        seg_error_q;
   logic        overrun_q;

   // {valid, value} for one digit; blank is legal only for hour tens
   function automatic logic [4:0] dec_digit(
      input logic [6:0] code,
      input logic       blank_ok
   );
      logic [4:0] r;
      case (code)
         7'h7E:   r = 5'h10;
         7'h30:   r = 5'h11;
         7'h6D:   r = 5'h12;
         7'h79:   r = 5'h13;
         7'h33:   r = 5'h14;
         7'h5B:   r = 5'h15;
         7'h5F:   r = 5'h16;
         7'h70:   r = 5'h17;
         7'h7F:   r = 5'h18;
         7'h7B:   r = 5'h19;
         7'h00:   r = blank_ok ? 5'h10 : 5'h00;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   assign din  = {bus.hr_seg, bus.min_seg, bus.am_pm};
   assign same = (din == samp);

   logic [4:0]  ht;
   logic [4:0]  hu;
   logic [4:0]  mt;
   logic [4:0]  mu;
   logic [6:0]  hour;
   logic [6:0]  minute;
   logic [4:0]  h24;
   logic [10:0] bin;
   logic        digits_ok;
   logic        range_ok;
   logic        pub;
   logic        err_set;
   logic        accept;

   always_comb begin
      ht        = dec_digit(samp[28:22], 1'b1);
      hu        = dec_digit(samp[21:15], 1'b0);
      mt        = dec_digit(samp[14:8], 1'b0);
      mu        = dec_digit(samp[7:1], 1'b0);
      hour      = 7'(ht[3:0]) * 7'd10 + 7'(hu[3:0]);
      minute    = 7'(mt[3:0]) * 7'd10 + 7'(mu[3:0]);
      digits_ok = ht[4] & hu[4] & mt[4] & mu[4];
      range_ok  = (hour >= 7'd1) && (hour <= 7'd12) && (minute <= 7'd59);
      // 12 o'clock is hour 0 of its half-day
      h24       = ((hour == 7'd12) ? 5'd0 : hour[4:0])
                  + (samp[0] ? 5'd12 : 5'd0);
      bin       = 11'(h24) * 11'd60 + 11'(minute);
      err_set   = (state == CHECK) && !(digits_ok && range_ok);
      pub       = (state == CHECK) && digits_ok && range_ok
                  && (bin != last_pub);
      accept    = time_valid_q && bus.time_ready;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state        <= WAIT;
         samp         <= '0;
         cnt          <= '0;
         last_pub     <= NO_TIME;
         time_out_q   <= '0;
         time_valid_q <= 1'b0;
         seg_error_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         samp <= din;
         if (!same)
            cnt <= 8'd1;
         else if (cnt < STABLE)
            cnt <= cnt + 8'd1;

         // The run must still hold on the edge that enters CHECK so the
         // decoded sample is the debounced one.
         case (state)
            WAIT:    if (same && cnt == STABLE) state <= CHECK;
            CHECK:   state <= same ? HOLD : WAIT;
            HOLD:    if (!same) state <= WAIT;
            default: state <= WAIT;
         endcase

         if (bus.err_clr) begin
            seg_error_q <= 1'b0;
            overrun_q   <= 1'b0;
         end
         if (err_set)
            seg_error_q <= 1'b1;

         if (pub) begin
            time_out_q   <= bin;
            time_valid_q <= 1'b1;
            last_pub     <= bin;
            if (time_valid_q && !bus.time_ready)
               overrun_q <= 1'b1;
         end else if (accept) begin
            time_valid_q <= 1'b0;
         end
      end
   end

`ifdef SEG_TICK_CHECK_EN
   logic        tick_error_q;
   logic [10:0] next_exp;
   logic        tick_bad;

   // 1439 -> 0 is the only legal wrap
   assign next_exp = (last_pub == 11'd1439) ? 11'd0 : last_pub + 11'd1;
   assign tick_bad = (last_pub != NO_TIME) && (bin != next_exp);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         tick_error_q <= 1'b0;
      end else begin
         if (bus.err_clr)
            tick_error_q <= 1'b0;
         if (pub && tick_bad)
            tick_error_q <= 1'b1;
      end
   end

   assign bus.tick_error = tick_error_q;
`else
   assign bus.tick_error = 1'b0;
`endif

   assign bus.time_out   = time_out_q;
   assign bus.time_valid = time_valid_q;
   assign bus.seg_error  = seg_error_q;
   assign bus.overrun    = overrun_q;

endmodule

// File: doc/seg_time_reader.md
Name: seg_time_reader

Overview:
- Receive-side counterpart of the binary-to-7-segment convertor: samples the two-digit hour display, the two-digit minute display and the AM/PM indicator.
- Debounces the displayed value, decodes it back to the 11-bit minutes-since-midnight time code, and publishes each new stable value over a valid/ready handshake.
- Used as a display loop-back checker and as a time source for downstream logic.

Parameters:
- STABLE_CYCLES, 4, consecutive identical registered samples required before a value is accepted (legal range 1..255).

Ports:
- CLK  input  1  system clock, rising edge
- RESET  input  1  asynchronous, active-high reset
- hr_seg  input  14  hour digits: [13:7] tens, [6:0] units; segment order a..g = bit 6..0 within each digit; active-high
- min_seg  input  14  minute digits, same layout as hr_seg
- am_pm  input  1  0 = AM, 1 = PM
- time_out  output  11  decoded minutes since midnight, 0..1439
- time_valid  output  1  time_out holds an unconsumed value
- time_ready  input  1  consumer accepts time_out when time_valid && time_ready
- seg_error  output  1  sticky: illegal pattern or out-of-range time seen
- overrun  output  1  sticky: a new value replaced an unconsumed one
- err_clr  input  1  synchronous clear of seg_error and overrun
- tick_error  output  1  see Optional Feature

Behaviour:
- Reset values: time_out = 0, time_valid = 0, seg_error = 0, overrun = 0, tick_error = 0. Stability counter = 0; last-published register = 0x7FF (no value).
- Digit codes (hex, a = MSB):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B.
  - Hour tens digit additionally accepts 00 (blank) as 0.
  - Any other code is illegal.
- Input stage: hr_seg, min_seg and am_pm are registered every cycle into a 29-bit sample.
- Stability counter:
  - Sample equal to the previous sample: counter increments, saturating at STABLE_CYCLES.
  - Any difference: counter = 1.
- FSM states:
  - WAIT: counter < STABLE_CYCLES. Transition to CHECK on the cycle the counter reaches STABLE_CYCLES.
  - CHECK: one cycle. Decode and range-check the sample.
    - Illegal digit, hours not in 1..12, or minutes > 59: set seg_error, go to HOLD without publishing.
    - Otherwise compute h24 = (h == 12 ? 0 : h) + (am_pm ? 12 : 0) and bin = h24*60 + m (11-bit result).
    - bin equal to the last published value: go to HOLD without publishing.
    - Otherwise register time_out = bin, set time_valid, update last-published, go to HOLD.
  - HOLD: stay while the sample is unchanged. Any sample change returns to WAIT with counter = 1.
- Latency: input stable before edge k gives time_valid high after edge k + STABLE_CYCLES + 1.
- Handshake:
  - time_valid stays high, with time_out stable, until a cycle with time_ready = 1; it clears on that edge.
  - time_ready while time_valid = 0 is ignored.
  - A publish in the same cycle as acceptance: the new value is loaded and time_valid stays 1. This is not an overrun.
  - A publish while time_valid = 1 without acceptance: time_out is overwritten and overrun is set.
- err_clr: clears both sticky flags. If it coincides with a new error, the set wins.
- Glitches shorter than STABLE_CYCLES never publish.
- RESET mid-operation: all state returns to reset values immediately. A pending time_valid is dropped.

Optional Feature:
- Macro: SEG_TICK_CHECK_EN.
- Defined:
  - On each publish after the first, tick_error (sticky, cleared by err_clr) is set if bin differs from (previous published + 1) mod 1440.
  - A wrap from 1439 to 0 is legal.
- Undefined: tick_error is tied to 0 and no comparator is built.

Test Plan:
- Reset release, then hr=7E/6D ("12"), min=7E/7E, am_pm=0 held, STABLE_CYCLES=4 -> time_valid rises 5 edges after inputs are applied, time_out = 0.
- hr=30/30 ("11"), min=5B/7B ("59"), am_pm=1, time_ready high -> time_out = 1439, time_valid high for one cycle.
- hr=00/30 ("1", blank tens), min=79/7E ("30"), am_pm=1 -> time_out = 810. A 3-cycle glitch to min=79/30 then back -> no new publish.
- hr=30/33 ("14") stable -> seg_error = 1, no time_valid. err_clr pulse -> seg_error = 0.
- Publish 10:00 (600) with time_ready = 0, then change to 10:01 -> time_out = 601, overrun = 1. Assert RESET while time_valid is high -> time_valid = 0 and time_out = 0 in the same cycle.
- With SEG_TICK_CHECK_EN defined: publish 1439 then 0 -> tick_error stays 0. Then publish 5 -> tick_error = 1.
